// File: rtl/uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_ctrl
//  Description : UART transmitter controller. Serialises one frame per
//                accepted request: start bit, DBIT data bits (LSB first),
//                optional parity bit and a stop period of SB_TICK ticks.
//                All bit timing is paced by a 16x-oversampling tick input.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_ctrl #(
    parameter int DBIT    = 8,   // data bits per frame, 5..8
    parameter int SB_TICK = 16,  // stop period in ticks: 16, 24 or 32
    parameter int PAR_EN  = 0,   // 1 inserts a parity bit after the data
    parameter int PAR_ODD = 0    // 0 even parity, 1 odd parity
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       s_tick,
    input  logic       tx_start,
    input  logic [7:0] din,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done_tick
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    // Last tick index of a start, data or parity bit (16 ticks per bit).
    localparam logic [4:0] BIT_LAST  = 5'd15;
    // Last tick index of the stop period.
    localparam logic [4:0] STOP_LAST = 5'(SB_TICK - 1);
    // Index of the final data bit.
    localparam logic [2:0] N_LAST    = 3'(DBIT - 1);
    // Mask selecting the data bits that take part in the parity sum.
    localparam logic [7:0] DIN_MASK  = 8'((1 << DBIT) - 1);
    // Parity seed: an odd-parity frame inverts the plain XOR of the data.
    localparam logic       PAR_SEED  = (PAR_ODD != 0);
    // Whether the parity state is part of the frame at all.
    localparam logic       USE_PAR   = (PAR_EN != 0);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  s_q,     s_d;      // tick counter within the current bit
    logic [2:0]  n_q,     n_d;      // data bit counter
    logic [7:0]  b_q,     b_d;      // shift register, bit 0 is on the line
    logic        p_q,     p_d;      // parity bit of the frame in flight
    logic        tx_q,    tx_d;     // registered serial line

    // State, counters, data and line register; reset returns to an idle line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            s_q     <= 5'd0;
            n_q     <= 3'd0;
            b_q     <= 8'd0;
            p_q     <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            p_q     <= p_d;
            tx_q    <= tx_d;
        end
    end

    // Next-state, counter and datapath update; nothing moves without s_tick
    // except the request acceptance in IDLE.
    always_comb begin
        state_d      = state_q;
        s_d          = s_q;
        n_d          = n_q;
        b_d          = b_q;
        p_d          = p_q;
        tx_done_tick = 1'b0;

        case (state_q)
            IDLE: begin
                if (tx_start) begin
                    b_d     = din;
                    p_d     = (^(din & DIN_MASK)) ^ PAR_SEED;
                    s_d     = 5'd0;
                    state_d = START;
                end
            end

            START: begin
                if (s_tick) begin
                    if (s_q == BIT_LAST) begin
                        s_d     = 5'd0;
                        n_d     = 3'd0;
                        state_d = DATA;
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end

            DATA: begin
                if (s_tick) begin
                    if (s_q == BIT_LAST) begin
                        s_d = 5'd0;
                        b_d = {1'b0, b_q[7:1]};
                        if (n_q == N_LAST) begin
                            state_d = USE_PAR ? PARITY : STOP;
                        end else begin
                            n_d = n_q + 3'd1;
                        end
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end

            PARITY: begin
                if (s_tick) begin
                    if (s_q == BIT_LAST) begin
                        s_d     = 5'd0;
                        state_d = STOP;
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end

            STOP: begin
                if (s_tick) begin
                    if (s_q == STOP_LAST) begin
                        // The completion pulse coincides with the last stop
                        // cycle, so the controller is still busy while it is
                        // high and a held request is taken in the next cycle.
                        state_d      = IDLE;
                        tx_done_tick = 1'b1;
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Line value for the state being entered, so the pin is a plain flop
    // that changes on the same edge as the state.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            IDLE:    tx_d = 1'b1;
            START:   tx_d = 1'b0;
            DATA:    tx_d = b_d[0];
            PARITY:  tx_d = p_d;
            STOP:    tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
    end

    assign tx      = tx_q;
    assign tx_busy = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_ctrl
//  Description : Self-checking bench for uart_tx_ctrl. Four instances cover
//                the default frame, even and odd parity, and a 7-bit frame
//                with two stop bits. Expected line activity comes from a
//                frame model: a list of (bit value, tick count) segments
//                consumed as ticks are issued.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_ctrl;

    localparam int NDUT = 4;
    localparam int DBIT_A [NDUT] = '{8, 8, 8, 7};
    localparam int SB_A   [NDUT] = '{16, 16, 16, 32};
    localparam int PEN_A  [NDUT] = '{0, 1, 1, 0};
    localparam int PODD_A [NDUT] = '{0, 0, 1, 0};

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       s_tick   [NDUT];
    logic       tx_start [NDUT];
    logic [7:0] din      [NDUT];
    logic       tx_o     [NDUT];
    logic       busy_o   [NDUT];
    logic       done_o   [NDUT];

    // Tick generation: per[i] > 0 gives one tick every per[i] clocks,
    // per[i] == 0 gives a random tick pattern.
    int per   [NDUT];
    int phase [NDUT];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    uart_tx_ctrl #(.DBIT(8), .SB_TICK(16), .PAR_EN(0), .PAR_ODD(0)) dut0 (
        .clk(clk), .reset(reset), .s_tick(s_tick[0]), .tx_start(tx_start[0]),
        .din(din[0]), .tx(tx_o[0]), .tx_busy(busy_o[0]), .tx_done_tick(done_o[0]));
    uart_tx_ctrl #(.DBIT(8), .SB_TICK(16), .PAR_EN(1), .PAR_ODD(0)) dut1 (
        .clk(clk), .reset(reset), .s_tick(s_tick[1]), .tx_start(tx_start[1]),
        .din(din[1]), .tx(tx_o[1]), .tx_busy(busy_o[1]), .tx_done_tick(done_o[1]));
    uart_tx_ctrl #(.DBIT(8), .SB_TICK(16), .PAR_EN(1), .PAR_ODD(1)) dut2 (
        .clk(clk), .reset(reset), .s_tick(s_tick[2]), .tx_start(tx_start[2]),
        .din(din[2]), .tx(tx_o[2]), .tx_busy(busy_o[2]), .tx_done_tick(done_o[2]));
    uart_tx_ctrl #(.DBIT(7), .SB_TICK(32), .PAR_EN(0), .PAR_ODD(0)) dut3 (
        .clk(clk), .reset(reset), .s_tick(s_tick[3]), .tx_start(tx_start[3]),
        .din(din[3]), .tx(tx_o[3]), .tx_busy(busy_o[3]), .tx_done_tick(done_o[3]));

    // Advance one clock. After the edge, pick the tick for the coming cycle,
    // then let combinational outputs settle before anything is sampled.
    task automatic cycle();
        @(posedge clk);
        #1;
        for (int i = 0; i < NDUT; i++) begin
            if (per[i] == 0) begin
                s_tick[i] = 1'($urandom_range(0, 1));
            end else begin
                phase[i] = (phase[i] + 1) % per[i];
                s_tick[i] = (phase[i] == 0);
            end
        end
        #1;
    endtask

    // Line must sit idle for ncyc clocks.
    task automatic idle_check(input int i, input int ncyc, input string name);
        for (int k = 0; k < ncyc; k++) begin
            n_cmp++;
            if (tx_o[i] !== 1'b1 || busy_o[i] !== 1'b0 || done_o[i] !== 1'b0) begin
                n_bad++;
                $display("FAIL %s dut%0d idle cyc %0d: tx=%b busy=%b done=%b, required tx=1 busy=0 done=0",
                         name, i, k, tx_o[i], busy_o[i], done_o[i]);
            end
            cycle();
        end
    endtask

    // Precondition: DUT i idle, tx_start[i]=1 and din[i]=d already driven.
    // Follows the whole frame against the segment model and returns the
    // frame length in clocks and the line value seen during the parity bit.
    task automatic check_frame(input int i, input logic [7:0] d, input bit hold,
                               input int pulse_at, input string name,
                               output int total, output logic par_obs);
        logic bitv [12];
        int   dur  [12];
        int   nseg, seg, rem, seglen, par_seg;
        logic par, exp_done;
        bit   last;

        nseg = 0;
        bitv[nseg] = 1'b0; dur[nseg] = 16; nseg++;
        par = (PODD_A[i] != 0);
        for (int k = 0; k < DBIT_A[i]; k++) begin
            bitv[nseg] = d[k]; dur[nseg] = 16; nseg++;
            par = par ^ d[k];
        end
        par_seg = -1;
        if (PEN_A[i] != 0) begin
            par_seg = nseg;
            bitv[nseg] = par; dur[nseg] = 16; nseg++;
        end
        bitv[nseg] = 1'b1; dur[nseg] = SB_A[i]; nseg++;

        par_obs = 1'bx;
        cycle();   // acceptance edge
        seg = 0; rem = dur[0]; seglen = 0; total = 0; last = 0;
        while (1) begin
            if (total == pulse_at) begin
                tx_start[i] = 1'b1;
                din[i]      = 8'hFF;
            end else begin
                if (!hold) tx_start[i] = 1'b0;
                din[i] = 8'($urandom);
            end
            exp_done = (seg == nseg - 1) && (rem == 1) && s_tick[i];
            n_cmp++;
            if (tx_o[i] !== bitv[seg]) begin
                n_bad++;
                $display("FAIL %s dut%0d tx seg %0d clk %0d: got %b, required %b",
                         name, i, seg, total, tx_o[i], bitv[seg]);
            end
            n_cmp++;
            if (busy_o[i] !== 1'b1) begin
                n_bad++;
                $display("FAIL %s dut%0d busy clk %0d: got %b, required 1", name, i, total, busy_o[i]);
            end
            n_cmp++;
            if (done_o[i] !== exp_done) begin
                n_bad++;
                $display("FAIL %s dut%0d done clk %0d: got %b, required %b",
                         name, i, total, done_o[i], exp_done);
            end
            if (seg == par_seg) par_obs = tx_o[i];
            total++;
            seglen++;
            if (s_tick[i]) begin
                rem--;
                if (rem == 0) begin
                    if (per[i] > 0 && seg > 0) begin
                        n_cmp++;
                        if (seglen != dur[seg] * per[i]) begin
                            n_bad++;
                            $display("FAIL %s dut%0d seg %0d length: got %0d clk, required %0d",
                                     name, i, seg, seglen, dur[seg] * per[i]);
                        end
                    end
                    seg++;
                    seglen = 0;
                    if (seg < nseg) rem = dur[seg];
                    else last = 1;
                end
            end
            cycle();
            if (last) break;
            if (total > 6000) begin
                n_cmp++; n_bad++;
                $display("FAIL %s dut%0d timeout: frame still running after %0d clk", name, i, total);
                break;
            end
        end
        // First cycle after the completion pulse: back in IDLE.
        n_cmp++;
        if (tx_o[i] !== 1'b1 || busy_o[i] !== 1'b0 || done_o[i] !== 1'b0) begin
            n_bad++;
            $display("FAIL %s dut%0d post-frame: tx=%b busy=%b done=%b, required tx=1 busy=0 done=0",
                     name, i, tx_o[i], busy_o[i], done_o[i]);
        end
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #1;   // no clock edge has occurred yet
        for (int i = 0; i < NDUT; i++) begin
            n_cmp++;
            if (tx_o[i] !== 1'b1) begin
                n_bad++; $display("FAIL reset_tx dut%0d: got %b, required 1", i, tx_o[i]);
            end
            n_cmp++;
            if (busy_o[i] !== 1'b0) begin
                n_bad++; $display("FAIL reset_busy dut%0d: got %b, required 0", i, busy_o[i]);
            end
            n_cmp++;
            if (done_o[i] !== 1'b0) begin
                n_bad++; $display("FAIL reset_done dut%0d: got %b, required 0", i, done_o[i]);
            end
        end
        repeat (2) cycle();
        reset = 1'b0;
        for (int i = 0; i < NDUT; i++) idle_check(i, 2, "after_reset");
    endtask

    task automatic test_basic();
        int t; logic p; logic [7:0] d;
        tx_start[0] = 1'b1; din[0] = 8'h55;
        check_frame(0, 8'h55, 0, -1, "basic55", t, p);
        // one start + eight data + one stop bit, 16 clocks each
        n_cmp++;
        if (t != 160) begin
            n_bad++; $display("FAIL basic55_len: done after %0d clk, required 160", t);
        end
        idle_check(0, 10, "basic55_idle");
        for (int k = 0; k < 3; k++) begin
            d = 8'($urandom);
            tx_start[0] = 1'b1; din[0] = d;
            check_frame(0, d, 0, -1, "basic_rand", t, p);
            idle_check(0, int'($urandom_range(1, 5)), "basic_rand_idle");
        end
    endtask

    task automatic test_parity();
        int t; logic p; logic [7:0] d;
        tx_start[1] = 1'b1; din[1] = 8'h07;
        check_frame(1, 8'h07, 0, -1, "par_even07", t, p);
        n_cmp++;
        if (p !== 1'b1) begin
            n_bad++; $display("FAIL par_even07_bit: got %b, required 1", p);
        end
        // start + 8 data + parity + stop = 11 bit times of 16 clocks
        n_cmp++;
        if (t != 176) begin
            n_bad++; $display("FAIL par_even07_len: done after %0d clk, required 176", t);
        end
        tx_start[2] = 1'b1; din[2] = 8'h07;
        check_frame(2, 8'h07, 0, -1, "par_odd07", t, p);
        n_cmp++;
        if (p !== 1'b0) begin
            n_bad++; $display("FAIL par_odd07_bit: got %b, required 0", p);
        end
        for (int k = 0; k < 2; k++) begin
            d = 8'($urandom);
            tx_start[1] = 1'b1; din[1] = d;
            check_frame(1, d, 0, -1, "par_even_rand", t, p);
            d = 8'($urandom);
            tx_start[2] = 1'b1; din[2] = d;
            check_frame(2, d, 0, -1, "par_odd_rand", t, p);
        end
    endtask

    task automatic test_dbit7();
        int t; logic p; logic [7:0] d;
        // bit 7 low: had it been sent, the line would be low where stop is due
        tx_start[3] = 1'b1; din[3] = 8'h00;
        check_frame(3, 8'h00, 0, -1, "dbit7_00", t, p);
        idle_check(3, 3, "dbit7_idle");
        d = 8'($urandom) & 8'h7F;
        tx_start[3] = 1'b1; din[3] = d;
        check_frame(3, d, 0, -1, "dbit7_rand", t, p);
    endtask

    task automatic test_busy_ignore();
        int t; logic p;
        tx_start[0] = 1'b1; din[0] = 8'h00;
        check_frame(0, 8'h00, 0, 48, "ignore_start", t, p);
        idle_check(0, 40, "ignore_no_second");
    endtask

    task automatic test_back_to_back();
        int t; logic p; logic [7:0] d1, d2;
        d1 = 8'($urandom); d2 = 8'($urandom);
        tx_start[0] = 1'b1; din[0] = d1;
        check_frame(0, d1, 1, -1, "b2b_first", t, p);
        din[0] = d2;   // request still high in this idle cycle
        check_frame(0, d2, 0, -1, "b2b_second", t, p);
        idle_check(0, 5, "b2b_idle");
    endtask

    task automatic test_reset_mid_frame();
        int t; logic p;
        tx_start[0] = 1'b1; din[0] = 8'($urandom);
        cycle();
        tx_start[0] = 1'b0;
        repeat (40) cycle();   // well inside the data bits
        reset = 1'b1;
        #1;
        for (int i = 0; i < NDUT; i++) begin
            n_cmp++;
            if (tx_o[i] !== 1'b1 || busy_o[i] !== 1'b0 || done_o[i] !== 1'b0) begin
                n_bad++;
                $display("FAIL midreset dut%0d: tx=%b busy=%b done=%b, required tx=1 busy=0 done=0",
                         i, tx_o[i], busy_o[i], done_o[i]);
            end
        end
        cycle();
        reset = 1'b0;
        idle_check(0, 3, "midreset_idle");
        tx_start[0] = 1'b1; din[0] = 8'hA3;
        check_frame(0, 8'hA3, 0, -1, "midreset_a3", t, p);
        n_cmp++;
        if (t != 160) begin
            n_bad++; $display("FAIL midreset_a3_len: done after %0d clk, required 160", t);
        end
    endtask

    task automatic test_random_ticks();
        int t; logic p; logic [7:0] d;
        for (int i = 0; i < NDUT; i++) per[i] = 0;
        for (int i = 0; i < NDUT; i++) begin
            for (int k = 0; k < 2; k++) begin
                d = 8'($urandom);
                tx_start[i] = 1'b1; din[i] = d;
                check_frame(i, d, 0, -1, "rand_ticks", t, p);
                idle_check(i, int'($urandom_range(1, 4)), "rand_ticks_idle");
            end
        end
    endtask

    initial begin
        for (int i = 0; i < NDUT; i++) begin
            s_tick[i]   = 1'b0;
            tx_start[i] = 1'b0;
            din[i]      = 8'h00;
            phase[i]    = 0;
        end
        per[0] = 1; per[1] = 1; per[2] = 1; per[3] = 3;

        test_reset();
        test_basic();
        test_parity();
        test_dbit7();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid_frame();
        test_random_ticks();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
